// File: rtl/fp_pkg.sv
// Shared types and constants for the iterative binary64 multiplier.
package fp_pkg;

   // Control states of the multiplier sequencer
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MUL   = 3'd1,
      NORM  = 3'd2,
      ROUND = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int MANT_W = 53;   // significand width including hidden bit
   localparam int PROD_W = 106;  // full significand product width

   // Exponents are carried as 13-bit two's complement throughout
   localparam logic signed [12:0] EXP_BIAS = 13'sd1023;
   localparam logic signed [12:0] EMIN     = -13'sd1022;
   localparam logic signed [12:0] EMAX     = 13'sd1023;

   localparam logic [63:0] QNAN_DEFAULT = 64'h7FF8_0000_0000_0000;

   // Counter value of the final shift-add iteration (53 iterations: 0..52)
   localparam logic [5:0] MUL_LAST = 6'd52;

   // Signed infinity pattern
   function automatic logic [63:0] inf_of(input logic sign);
      return {sign, 11'h7FF, 52'h0};
   endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even and binary64 packing of a normalised product.
// prod holds the significand with the binary point after bit 104.
module fp_round_pack
   import fp_pkg::*;
(
   input  logic         sign,
   input  logic [12:0]  exp_in,
   input  logic [104:0] prod,
   input  logic         sticky,
   output logic [63:0]  result,
   output logic         overflow,
   output logic         underflow,
   output logic         inexact
);

   logic [52:0] sig;
   logic        guard;
   logic        sticky_all;
   logic        round_up;
   logic        tiny;
   logic [53:0] sig_inc;
   logic [52:0] sig_fin;
   logic [12:0] exp_fin;
   logic [10:0] exp_biased;

   // Round the 53-bit significand and select overflow / denormal / normal encoding
   always_comb begin
      sig        = prod[104:52];
      guard      = prod[51];
      sticky_all = sticky | (|prod[50:0]);
      round_up   = guard & (sig[0] | sticky_all);
      tiny       = ~sig[52];
      sig_inc    = {1'b0, sig} + {53'd0, round_up};
      if (sig_inc[53]) begin
         // carry out of the significand: 2^53 becomes 2^52 with exponent bump
         sig_fin = sig_inc[53:1];
         exp_fin = exp_in + 13'd1;
      end else begin
         sig_fin = sig_inc[52:0];
         exp_fin = exp_in;
      end
      // low 11 bits suffice: only used when exp_fin lies in -1022..1023
      exp_biased = exp_fin[10:0] + $unsigned(EXP_BIAS[10:0]);
      inexact    = guard | sticky_all;
      overflow   = 1'b0;
      underflow  = 1'b0;
      if ($signed(exp_fin) > EMAX) begin
         result   = inf_of(sign);
         overflow = 1'b1;
         inexact  = 1'b1;
      end else if (!sig_fin[52]) begin
         result    = {sign, 11'h000, sig_fin[51:0]};
         underflow = tiny & inexact;
      end else begin
         result = {sign, exp_biased, sig_fin[51:0]};
      end
   end

endmodule

// File: rtl/fp_mul_iter.sv
// Iterative binary64 multiplier fed by decomposed operands.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// in_ready is high only in IDLE, out_valid stays high with result/flags stable
// until the edge where out_ready is also high.
module fp_mul_iter
   import fp_pkg::*;
#(
   parameter logic [63:0] QNAN = QNAN_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        a_sign,
   input  logic        b_sign,
   input  logic [11:0] a_exponent,
   input  logic [11:0] b_exponent,
   input  logic [52:0] a_mantissa,
   input  logic [52:0] b_mantissa,
   input  logic        a_is_nan,
   input  logic        a_is_inf,
   input  logic        a_is_zero,
   input  logic        b_is_nan,
   input  logic        b_is_inf,
   input  logic        b_is_zero,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] result,
   output logic        flag_invalid,
   output logic        flag_overflow,
   output logic        flag_underflow,
   output logic        flag_inexact
);

   state_t       state, state_nxt;
   logic [105:0] prod_q;
   logic [105:0] mcand_q;
   logic [52:0]  mplier_q;
   logic [12:0]  exp_q;
   logic [5:0]   cnt_q;
   logic         sticky_q;
   logic         sign_q;

   logic         accept;
   logic         special;
   logic [63:0]  special_result;
   logic         special_invalid;
   logic         prod_nz;
   logic         norm_rshift;
   logic         norm_lshift;

   logic [63:0]  rp_result;
   logic         rp_overflow;
   logic         rp_underflow;
   logic         rp_inexact;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid & in_ready;
   assign special  = a_is_nan | a_is_inf | a_is_zero | b_is_nan | b_is_inf | b_is_zero;

   // Result for NaN / infinity / zero operands, produced without iterating
   always_comb begin
      special_invalid = 1'b0;
      if (a_is_nan | b_is_nan | (a_is_inf & b_is_zero) | (a_is_zero & b_is_inf)) begin
         special_result  = QNAN;
         special_invalid = 1'b1;
      end else if (a_is_inf | b_is_inf) begin
         special_result = inf_of(a_sign ^ b_sign);
      end else begin
         special_result = {a_sign ^ b_sign, 63'h0};
      end
   end

   // Normalisation decisions: right shift has priority, left shift only above EMIN
   always_comb begin
      prod_nz     = |prod_q;
      norm_rshift = prod_q[105] | (($signed(exp_q) < EMIN) & prod_nz);
      norm_lshift = ~prod_q[104] & ($signed(exp_q) > EMIN) & prod_nz;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = special ? DONE : MUL;
         MUL:     if (cnt_q == MUL_LAST) state_nxt = NORM;
         NORM:    if (!norm_rshift && !norm_lshift) state_nxt = ROUND;
         ROUND:   state_nxt = DONE;
         DONE:    if (out_valid && out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, shift-add loop and normalisation shifts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         exp_q    <= '0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
         sign_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               sign_q   <= a_sign ^ b_sign;
               exp_q    <= {a_exponent[11], a_exponent} + {b_exponent[11], b_exponent};
               mcand_q  <= {53'd0, a_mantissa};
               mplier_q <= b_mantissa;
               prod_q   <= '0;
               cnt_q    <= '0;
               sticky_q <= 1'b0;
            end
            MUL: begin
               if (mplier_q[0]) prod_q <= prod_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 6'd1;
            end
            NORM: begin
               if (norm_rshift) begin
                  prod_q   <= prod_q >> 1;
                  sticky_q <= sticky_q | prod_q[0];
                  exp_q    <= exp_q + 13'd1;
               end else if (norm_lshift) begin
                  prod_q <= prod_q << 1;
                  exp_q  <= exp_q - 13'd1;
               end
            end
            default: ;
         endcase
      end
   end

   fp_round_pack u_round_pack (
      .sign      (sign_q),
      .exp_in    (exp_q),
      .prod      (prod_q[104:0]),
      .sticky    (sticky_q),
      .result    (rp_result),
      .overflow  (rp_overflow),
      .underflow (rp_underflow),
      .inexact   (rp_inexact)
   );

   // Result/flag registers and output valid; valid rises one cycle after entering DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result         <= '0;
         flag_invalid   <= 1'b0;
         flag_overflow  <= 1'b0;
         flag_underflow <= 1'b0;
         flag_inexact   <= 1'b0;
         out_valid      <= 1'b0;
      end else begin
         if (accept && special) begin
            result         <= special_result;
            flag_invalid   <= special_invalid;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
         end else if (state == ROUND) begin
            result         <= rp_result;
            flag_invalid   <= 1'b0;
            flag_overflow  <= rp_overflow;
            flag_underflow <= rp_underflow;
            flag_inexact   <= rp_inexact;
         end
         if (state == DONE) out_valid <= ~(out_valid & out_ready);
         else               out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fp_mul_iter.sv
// Bench for fp_mul_iter: directed cases plus random operands against an
// exact-arithmetic reference of binary64 multiplication.
module tb_fp_mul_iter;

   localparam int CW = 72;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        a_sign = 1'b0, b_sign = 1'b0;
   logic [11:0] a_exponent = '0, b_exponent = '0;
   logic [52:0] a_mantissa = '0, b_mantissa = '0;
   logic        a_is_nan = 1'b0, a_is_inf = 1'b0, a_is_zero = 1'b0;
   logic        b_is_nan = 1'b0, b_is_inf = 1'b0, b_is_zero = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] result;
   logic        flag_invalid, flag_overflow, flag_underflow, flag_inexact;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // expected {result, invalid, overflow, underflow, inexact} and latency
   logic [67:0] exp_q[$];
   int          lat_q[$];

   fp_mul_iter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .a_sign         (a_sign),
      .b_sign         (b_sign),
      .a_exponent     (a_exponent),
      .b_exponent     (b_exponent),
      .a_mantissa     (a_mantissa),
      .b_mantissa     (b_mantissa),
      .a_is_nan       (a_is_nan),
      .a_is_inf       (a_is_inf),
      .a_is_zero      (a_is_zero),
      .b_is_nan       (b_is_nan),
      .b_is_inf       (b_is_inf),
      .b_is_zero      (b_is_zero),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .result         (result),
      .flag_invalid   (flag_invalid),
      .flag_overflow  (flag_overflow),
      .flag_underflow (flag_underflow),
      .flag_inexact   (flag_inexact)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] want);
      n_checks++;
      assert (got === want) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // what the upstream decomposer would present for a binary64 value
   function automatic void decomp(input logic [63:0] x, output logic s, output logic [11:0] e,
                                  output logic [52:0] m, output logic nan, output logic inf,
                                  output logic zero);
      logic [10:0] ef;
      logic [51:0] f;
      ef   = x[62:52];
      f    = x[51:0];
      s    = x[63];
      nan  = (ef == 11'h7FF) && (f != 0);
      inf  = (ef == 11'h7FF) && (f == 0);
      zero = (ef == 11'h000) && (f == 0);
      if (ef == 11'h000) begin
         e = 12'hC02;  // -1022
         m = {1'b0, f};
      end else begin
         e = 12'(int'(ef) - 1023);
         m = {1'b1, f};
      end
   endfunction

   // exact product rounded to nearest-even, plus expected cycle latency
   function automatic logic [67:0] ref_mul(input logic [63:0] a, input logic [63:0] b, output int lat);
      logic         sx, a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
      logic [127:0] p, q, rem, half;
      logic [52:0]  ma, mb;
      logic [10:0]  be;
      logic         tiny, inexact, up, unf;
      int           xa, xb, e0, k, x, big_e, d, shifts, msb, e;
      sx     = a[63] ^ b[63];
      a_nan  = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
      a_inf  = (a[62:52] == 11'h7FF) && (a[51:0] == 0);
      a_zero = (a[62:52] == 11'h000) && (a[51:0] == 0);
      b_nan  = (b[62:52] == 11'h7FF) && (b[51:0] != 0);
      b_inf  = (b[62:52] == 11'h7FF) && (b[51:0] == 0);
      b_zero = (b[62:52] == 11'h000) && (b[51:0] == 0);
      lat = 1;
      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
         return {64'h7FF8_0000_0000_0000, 4'b1000};
      if (a_inf || b_inf) return {sx, 11'h7FF, 52'h0, 4'b0000};
      if (a_zero || b_zero) return {sx, 63'h0, 4'b0000};
      ma = (a[62:52] == 0) ? {1'b0, a[51:0]} : {1'b1, a[51:0]};
      mb = (b[62:52] == 0) ? {1'b0, b[51:0]} : {1'b1, b[51:0]};
      xa = (a[62:52] == 0) ? -1022 : int'(a[62:52]) - 1023;
      xb = (b[62:52] == 0) ? -1022 : int'(b[62:52]) - 1023;
      p  = 128'(ma) * 128'(mb);
      k  = 0;
      for (int i = 0; i < 128; i++) if (p[i]) k = i;
      e0 = xa + xb;  // value = p * 2^(e0-104)
      // latency: 56 plus one cycle per normalising shift
      msb = k; e = e0; shifts = 0;
      if (msb == 105) begin shifts++; msb--; e++; end
      if (e < -1022) shifts += ((-1022 - e) < (msb + 1)) ? (-1022 - e) : (msb + 1);
      else if (e > -1022 && msb < 104) shifts += ((104 - msb) < (e + 1022)) ? (104 - msb) : (e + 1022);
      lat = 56 + shifts;
      // rounding at quantum 2^(E-52), E clamped to the minimum normal exponent
      x     = k + e0 - 104;
      tiny  = (x < -1022);
      big_e = tiny ? -1022 : x;
      d     = big_e - 52 - (e0 - 104);
      up = 1'b0; inexact = 1'b0;
      if (d <= 0) begin
         q = p << (-d);
      end else if (d >= 120) begin
         q = '0;
         inexact = 1'b1;
      end else begin
         q    = p >> d;
         rem  = p & ((128'd1 << d) - 128'd1);
         half = 128'd1 << (d - 1);
         inexact = (rem != 0);
         up = (rem > half) || ((rem == half) && q[0]);
      end
      if (up) q = q + 128'd1;
      if (q == (128'd1 << 53)) begin q = 128'd1 << 52; big_e++; end
      if (big_e > 1023) return {sx, 11'h7FF, 52'h0, 4'b0101};
      if (q < (128'd1 << 52)) begin
         unf = tiny && inexact;
         return {sx, 11'h000, q[51:0], 1'b0, 1'b0, unf, inexact};
      end
      be = 11'(big_e + 1023);
      return {sx, be, q[51:0], 3'b000, inexact};
   endfunction

   function automatic logic [63:0] rand_fp();
      logic [63:0] r;
      logic [51:0] f;
      logic [10:0] ex;
      int sel, kind;
      r   = {$urandom(), $urandom()};
      f   = r[51:0];
      sel = $urandom_range(0, 9);
      case (sel)
         0: begin
            kind = $urandom_range(0, 2);
            if (kind == 0)      begin ex = 11'h000; f = '0; end
            else if (kind == 1) begin ex = 11'h7FF; f = '0; end
            else                begin ex = 11'h7FF; f[0] = 1'b1; end
         end
         1: begin ex = 11'h000; if (f == 0) f = 52'd1; end
         2: ex = 11'($urandom_range(1, 40));
         3: ex = 11'($urandom_range(2000, 2046));
         4: begin ex = 11'($urandom_range(1000, 1046)); f = f & {12'hFFF, 40'h0}; end
         default: ex = 11'($urandom_range(983, 1063));
      endcase
      return {r[63], ex, f};
   endfunction

   // driver: present one operand pair, collect the result, optionally stall the consumer
   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [67:0] want_v, input int want_lat, input int hold);
      int          lat;
      logic [67:0] got, want;
      @(negedge clk);
      decomp(a, a_sign, a_exponent, a_mantissa, a_is_nan, a_is_inf, a_is_zero);
      decomp(b, b_sign, b_exponent, b_mantissa, b_is_nan, b_is_inf, b_is_zero);
      out_ready = (hold == 0);
      check({tag, " in_ready idle"}, CW'(in_ready), CW'(1));
      in_valid = 1'b1;
      @(posedge clk);
      exp_q.push_back(want_v);
      lat_q.push_back(want_lat);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 400) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({tag, " latency"}, CW'(lat), CW'(lat_q.pop_front()));
      want = exp_q.pop_front();
      got  = {result, flag_invalid, flag_overflow, flag_underflow, flag_inexact};
      check({tag, " result/flags"}, {4'h0, got}, {4'h0, want});
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         got = {result, flag_invalid, flag_overflow, flag_underflow, flag_inexact};
         check({tag, " held"}, {2'b00, out_valid, in_ready, got}, {2'b00, 1'b1, 1'b0, want});
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, " released"}, CW'({out_valid, in_ready}), CW'(2'b01));
   endtask

   initial begin
      logic [63:0] a, b;
      logic [67:0] want;
      int          l;

      // reset state
      repeat (3) @(negedge clk);
      check("reset state", {2'b00, in_ready, out_valid, result, flag_invalid, flag_overflow,
            flag_underflow, flag_inexact}, {2'b00, 1'b1, 1'b0, 64'h0, 4'b0000});
      rst_n = 1'b1;

      // directed cases
      run_op("1.5*2", 64'h3FF8_0000_0000_0000, 64'h4000_0000_0000_0000,
             {64'h4008_0000_0000_0000, 4'b0000}, 56, 0);
      run_op("inf*0", 64'h7FF0_0000_0000_0000, 64'h0000_0000_0000_0000,
             {64'h7FF8_0000_0000_0000, 4'b1000}, 1, 0);
      run_op("-inf*2", 64'hFFF0_0000_0000_0000, 64'h4000_0000_0000_0000,
             {64'hFFF0_0000_0000_0000, 4'b0000}, 1, 0);
      run_op("nan*1", 64'h7FF8_0000_0000_0001, 64'h3FF0_0000_0000_0000,
             {64'h7FF8_0000_0000_0000, 4'b1000}, 1, 0);
      run_op("-0*5", 64'h8000_0000_0000_0000, 64'h4014_0000_0000_0000,
             {64'h8000_0000_0000_0000, 4'b0000}, 1, 0);
      run_op("max*2", 64'h7FEF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000,
             {64'h7FF0_0000_0000_0000, 4'b0101}, 56, 0);
      run_op("minnorm*0.5", 64'h0010_0000_0000_0000, 64'h3FE0_0000_0000_0000,
             {64'h0008_0000_0000_0000, 4'b0000}, 57, 0);
      run_op("mindenorm*0.5", 64'h0000_0000_0000_0001, 64'h3FE0_0000_0000_0000,
             {64'h0000_0000_0000_0000, 4'b0011}, 57, 0);
      run_op("backpressure", 64'h3FF8_0000_0000_0000, 64'h4000_0000_0000_0000,
             {64'h4008_0000_0000_0000, 4'b0000}, 56, 10);

      // reset while iterating aborts the operation
      @(negedge clk);
      decomp(64'h3FF8_0000_0000_0000, a_sign, a_exponent, a_mantissa, a_is_nan, a_is_inf, a_is_zero);
      decomp(64'h4000_0000_0000_0000, b_sign, b_exponent, b_mantissa, b_is_nan, b_is_inf, b_is_zero);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (19) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset mid-op", CW'({out_valid, in_ready}), CW'(2'b01));
      @(negedge clk);
      check("reset mid-op result", CW'(result), CW'(0));
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after reset", 64'h3FF8_0000_0000_0000, 64'h4000_0000_0000_0000,
             {64'h4008_0000_0000_0000, 4'b0000}, 56, 0);

      // random operands against the reference
      for (int i = 0; i < 40; i++) begin
         a    = rand_fp();
         b    = rand_fp();
         want = ref_mul(a, b, l);
         run_op($sformatf("rand%0d %h*%h", i, a, b), a, b, want, l,
                ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
